// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory stage with bus handshake, stall and load extension
// Ports: clk, rst_n (sync active-low); mem_rd_en/mem_wr_en/inst_funct3/addr/store_data from the control path;
//   lsu_stall/lsu_done/lsu_err/load_data back to the core; bus_req/bus_we/bus_addr/bus_be/bus_wdata
//   driven to the data bus with bus_ready/bus_rdata returned.
// Optional feature: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of truncating.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_rd_en,
    input  logic        mem_wr_en,
    input  logic [2:0]  inst_funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        lsu_stall,
    output logic        lsu_done,
    output logic        lsu_err,
    output logic [31:0] load_data,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state, state_nx;
    logic [31:0] addr_q, data_q, cnt, ext, wdata;
    logic [2:0]  f3_q;
    logic [1:0]  sz;
    logic        we_q, err_q, both, misalign, timeout, sgn;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [3:0]  be;

    assign both = mem_rd_en & mem_wr_en;
`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = (inst_funct3[1:0] == 2'b01 & addr[0]) | (inst_funct3[1] & |addr[1:0]);
`else
    assign misalign = 1'b0;
`endif
    // TIMEOUT_CYCLES of zero disables the bus wait limit
    assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == 32'(TIMEOUT_CYCLES - 1));

    // funct3[1:0]: 00 byte, 01 half, anything else is a word access
    assign sz    = f3_q[1:0];
    assign sgn   = ~f3_q[2];
    assign rbyte = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign rhalf = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    assign ext   = sz == 2'b00 ? {{24{sgn & rbyte[7]}}, rbyte} :
                   sz == 2'b01 ? {{16{sgn & rhalf[15]}}, rhalf} : bus_rdata;
    assign be    = sz == 2'b00 ? 4'b0001 << addr_q[1:0] :
                   sz == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata = sz == 2'b00 ? {4{data_q[7:0]}} :
                   sz == 2'b01 ? {2{data_q[15:0]}} : data_q;

    // bus outputs are forced low outside REQ so reset leaves every output at zero
    assign bus_req   = state == REQ;
    assign bus_we    = bus_req & we_q;
    assign bus_addr  = bus_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign bus_be    = bus_req ? (we_q ? be : 4'b1111) : 4'd0;
    assign bus_wdata = bus_req ? wdata : 32'd0;
    assign lsu_stall = (state == IDLE & (mem_rd_en | mem_wr_en)) | bus_req;
    assign lsu_done  = state == DONE;
    assign lsu_err   = lsu_done & err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // DONE always returns to IDLE so a still-asserted request is not reissued
    always_comb begin
        state_nx = IDLE;
        if (state == IDLE && (mem_rd_en | mem_wr_en))
            state_nx = (both | misalign) ? DONE : REQ;
        else if (state == REQ)
            state_nx = (bus_ready | timeout) ? DONE : REQ;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q    <= '0;
            data_q    <= '0;
            f3_q      <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            cnt       <= '0;
            load_data <= '0;
        end else if (state == IDLE && (mem_rd_en | mem_wr_en)) begin
            addr_q <= addr;
            data_q <= store_data;
            f3_q   <= inst_funct3;
            we_q   <= mem_wr_en;
            cnt    <= '0;
            err_q  <= both | misalign;
            if (!both && misalign) load_data <= '0;
        end else if (state == REQ) begin
            if (bus_ready) begin
                if (!we_q) load_data <= ext;
            end else if (timeout) begin
                err_q     <= 1'b1;
                load_data <= '0;
            end else begin
                cnt <= cnt + 32'd1;
            end
        end
    end
endmodule
